// File: rtl/iteration_uart_tx.sv
// -----------------------------------------------------------------------------
// iteration_uart_tx
//
// Takes one 272-bit parser result, acknowledges it, and sends it to the host
// MCU as an 8N1 UART frame of 36 bytes:
//   byte 0      : SYNC_BYTE
//   bytes 1..34 : payload, most significant byte first
//   byte 35     : XOR of bytes 1..34 (the sync byte is not included)
// Each byte is a start bit, 8 data bits sent LSB first, and a stop bit.
// Every bit lasts exactly CLKS_PER_BIT clocks, and bytes follow each other
// with no gap.
//
// Parameters
//   CLKS_PER_BIT      clocks per UART bit, 4..65535 (625 = 72 MHz / 115200)
//   SYNC_BYTE         first byte of every frame
//
// Ports
//   clk_72MHz         sole clock, rising edge
//   reset_n           asynchronous active-low reset
//   sensor_iterations parser result, sampled only on the capture cycle
//   data_avl          parser holds an unconsumed result (level)
//   reset_parser      one-cycle acknowledge, issued the cycle after capture
//   tx                UART line, idles high
//   busy              high from capture until the last stop bit ends
//   frame_count       count of completed frames, wraps at 16 bits
// -----------------------------------------------------------------------------
module iteration_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 625,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic         clk_72MHz,
    input  logic         reset_n,
    input  logic [271:0] sensor_iterations,
    input  logic         data_avl,
    output logic         reset_parser,
    output logic         tx,
    output logic         busy,
    output logic [15:0]  frame_count
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [5:0]  DATA_BYTES = 6'd34;  // bytes 1..34 hold payload
    localparam logic [5:0]  LAST_BYTE  = 6'd35;  // checksum byte index
    localparam logic [2:0]  LAST_BIT   = 3'd7;

    state_t            state_q, state_d;
    // Byte 33 of the packed array is the MSB byte, which is data byte 1.
    logic [33:0][7:0]  buffer_q, buffer_d;
    logic [7:0]        checksum_q, checksum_d;
    logic [7:0]        shift_q, shift_d;      // byte on the line, bit 0 next
    logic [5:0]        byte_idx_q, byte_idx_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [15:0]       baud_cnt_q, baud_cnt_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              reset_parser_q, reset_parser_d;
    logic [15:0]       frame_count_q, frame_count_d;

    logic              bit_done;
    logic [5:0]        data_sel;
    logic [7:0]        next_byte;
    logic [7:0]        next_checksum;

    assign bit_done = (baud_cnt_q == BAUD_LAST);

    // The byte after byte_idx_q is data byte byte_idx_q+1. That is packed
    // element 33-byte_idx_q. After the last data byte it is the checksum,
    // which by then holds the XOR of all 34 data bytes.
    assign data_sel = 6'd33 - byte_idx_q;

    always_comb begin
        next_byte     = checksum_q;
        next_checksum = checksum_q;
        if (byte_idx_q < DATA_BYTES) begin
            next_byte     = buffer_q[data_sel];
            next_checksum = checksum_q ^ buffer_q[data_sel];
        end
    end

    always_comb begin
        // NOTE: every _d starts as its _q, so no branch of the case leaves a
        // signal unassigned and no latch can be inferred.
        state_d        = state_q;
        buffer_d       = buffer_q;
        checksum_d     = checksum_q;
        shift_d        = shift_q;
        byte_idx_d     = byte_idx_q;
        bit_idx_d      = bit_idx_q;
        baud_cnt_d     = baud_cnt_q;
        tx_d           = tx_q;
        busy_d         = busy_q;
        reset_parser_d = 1'b0;
        frame_count_d  = frame_count_q;

        unique case (state_q)
            IDLE: begin
                if (data_avl) begin
                    buffer_d       = sensor_iterations;
                    checksum_d     = 8'h00;
                    byte_idx_d     = 6'd0;
                    bit_idx_d      = 3'd0;
                    baud_cnt_d     = 16'd0;
                    shift_d        = SYNC_BYTE;
                    tx_d           = 1'b0;   // start bit of the sync byte
                    busy_d         = 1'b1;
                    reset_parser_d = 1'b1;
                    state_d        = START;
                end
            end

            START: begin
                if (bit_done) begin
                    baud_cnt_d = 16'd0;
                    bit_idx_d  = 3'd0;
                    tx_d       = shift_q[0];
                    state_d    = DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end

            DATA: begin
                if (bit_done) begin
                    baud_cnt_d = 16'd0;
                    if (bit_idx_q == LAST_BIT) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end

            STOP: begin
                if (bit_done) begin
                    baud_cnt_d = 16'd0;
                    if (byte_idx_q != LAST_BYTE) begin
                        // Load the next byte straight into a start bit, so
                        // there is no idle time between bytes.
                        byte_idx_d = byte_idx_q + 6'd1;
                        shift_d    = next_byte;
                        checksum_d = next_checksum;
                        tx_d       = 1'b0;
                        state_d    = START;
                    end else begin
                        frame_count_d = frame_count_q + 16'd1;
                        busy_d        = 1'b0;
                        tx_d          = 1'b1;
                        state_d       = IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_72MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            // NOTE: the payload buffer is a flop bank, not a RAM, so it can
            // be reset with the control state. This keeps every register
            // deterministic after reset.
            buffer_q       <= '0;
            checksum_q     <= 8'h00;
            shift_q        <= 8'h00;
            byte_idx_q     <= 6'd0;
            bit_idx_q      <= 3'd0;
            baud_cnt_q     <= 16'd0;
            tx_q           <= 1'b1;
            busy_q         <= 1'b0;
            reset_parser_q <= 1'b0;
            frame_count_q  <= 16'd0;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples the
            // values from before the edge, whatever order the lines are in.
            state_q        <= state_d;
            buffer_q       <= buffer_d;
            checksum_q     <= checksum_d;
            shift_q        <= shift_d;
            byte_idx_q     <= byte_idx_d;
            bit_idx_q      <= bit_idx_d;
            baud_cnt_q     <= baud_cnt_d;
            tx_q           <= tx_d;
            busy_q         <= busy_d;
            reset_parser_q <= reset_parser_d;
            frame_count_q  <= frame_count_d;
        end
    end

    assign tx           = tx_q;
    assign busy         = busy_q;
    assign reset_parser = reset_parser_q;
    assign frame_count  = frame_count_q;

endmodule

// File: doc/iteration_uart_tx.md
# iteration_uart_tx

Downstream consumer of the octo-receiver parser output. When `data_avl` is high, it captures the 272-bit `sensor_iterations` word and acknowledges it with a one-cycle `reset_parser` pulse. It then serialises the word to the host MCU as a framed 8N1 UART stream: one sync byte, 34 data bytes and an XOR checksum. It sits between the parser and the top-level `tx` pad, in the 72 MHz domain.

## Interface
- `CLKS_PER_BIT`, default 625: clock cycles per UART bit (72 MHz / 115200). Legal range 4..65535.
- `SYNC_BYTE`, default 8'hA5: first byte of every frame.
- `clk_72MHz`  input  1: sole clock; all logic is on its rising edge.
- `reset_n`  input  1: asynchronous, active-low reset.
  - Asserting it forces all state to reset values immediately.
  - Deassertion is synchronous in effect (first active edge after release).
- `sensor_iterations`  input  272: parser result. Valid while `data_avl`=1.
- `data_avl`  input  1: level. High while the parser holds an unconsumed result.
- `reset_parser`  output  1: one-cycle acknowledge. Parser clears `data_avl` and re-arms.
- `tx`  output  1: UART line. Idles high.
- `busy`  output  1: high from capture until the last stop bit completes.
- `frame_count`  output  16: frames fully transmitted. Wraps 16'hFFFF→0.

## Operation
- States: IDLE, START, DATA, STOP.
  - Byte index `byte_idx` runs 0..35 (0 = sync, 1..34 = data, 35 = checksum).
  - Bit index runs 0..7.
  - Baud counter is 16 bits.
- IDLE: `tx`=1, `busy`=0. On a cycle with `data_avl`=1:
  - latch `sensor_iterations` into a 272-bit buffer;
  - clear checksum to 0 and set `byte_idx`=0;
  - go to START.
- Data byte k (1..34) is `buffer[271-8(k-1) -: 8]`, i.e. MSB byte first.
- Checksum is the XOR of data bytes 1..34; the sync byte is excluded. It accumulates as each data byte is loaded.
- START: `tx`=0 for CLKS_PER_BIT cycles → DATA.
- DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles → STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles. Then:
  - if `byte_idx`<35: increment `byte_idx` → START (no inter-byte gap);
  - else: increment `frame_count` → IDLE.
- `data_avl` is ignored outside IDLE. The parser holds its result, so a result arriving mid-frame is taken at the next IDLE cycle, if still asserted.
- The input is not sampled except at the capture cycle. Buffer contents are frozen for the whole frame.

## Timing
- Reset values: `tx`=1, `busy`=0, `reset_parser`=0, `frame_count`=0, state IDLE, buffer and checksum 0.
- Capture cycle is T (IDLE, `data_avl`=1 at edge T).
  - `reset_parser`=1 during T+1 only.
  - `busy`=1 from T+1.
  - `tx` falls at T+1 (start bit of sync byte).
- Frame length: exactly 36×10×CLKS_PER_BIT cycles from T+1.
  - Last stop-bit cycle: L = T + 360×CLKS_PER_BIT.
  - At L+1: `busy`=0, `frame_count` incremented, state IDLE.
  - If `data_avl`=1 at edge L+1, that edge is the next capture. Line stays high ≥1 cycle between frames.
- Bit boundaries are exact. No fractional-baud correction.
- `reset_n` asserted mid-frame:
  - `tx` returns high asynchronously;
  - the frame is abandoned; no partial checksum is sent;
  - `frame_count` is not incremented;
  - no `reset_parser` pulse is issued.
- `reset_parser` is never asserted twice per capture. It is never asserted while `busy` was already 1.

## Test plan
- Single frame:
  - Stimulus: CLKS_PER_BIT=4; data bytes 8'h01..8'h22 (MSB byte = 8'h01); `data_avl` pulse held until `reset_parser`.
  - Required: UART decode gives A5, 01..22, checksum 23.
  - Required: frame lasts 1440 cycles; exactly one `reset_parser` pulse, at T+1; `frame_count`=1.
- All-zero payload:
  - Stimulus: `sensor_iterations`=0.
  - Required: A5 followed by 34× 00, checksum 00; `tx` low exactly for start bits and zero data bits.
- Back-to-back:
  - Stimulus: `data_avl` held high continuously with two different payloads; second payload applied after the first `reset_parser`.
  - Required: two frames separated by exactly one idle-high cycle; `frame_count`=2; second frame carries second payload.
- Mid-frame arrival:
  - Stimulus: `data_avl` raised at byte 10 of a frame.
  - Required: no `reset_parser` until IDLE; capture at L+1; first frame bytes unchanged.
- Reset mid-frame:
  - Stimulus: `reset_n` low during byte 20 DATA state.
  - Required: `tx`=1, `busy`=0 within the same cycle (async); `frame_count`=0.
  - Required: after release with `data_avl`=1, a full fresh frame from sync byte.
- Baud check:
  - Stimulus: default CLKS_PER_BIT=625.
  - Required: start-bit low width exactly 625 cycles; full frame 225000 cycles.
